// File: rtl/mips_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mips_lsu
// Brief    : M-stage load/store unit for the pipelined MIPS core. Issues
//            handshaked data-memory accesses, stalls the pipeline while an
//            access is in flight, aligns and extends load data, and raises
//            address-error pulses for misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mips_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                flush,
    output logic                stall,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                adel,
    output logic                ades,
    output logic [ADDR_W-1:0]   badvaddr,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [OFF_W-1:0]    req_off;
    logic                req_aligned;
    logic [BE_W-1:0]     req_be;
    logic [DATA_W-1:0]   req_wdata_rep;
    logic                misaligned;
    logic                accept;
    logic [DATA_W-1:0]   ld_shifted;
    logic [DATA_W-1:0]   ld_mask;
    logic                ld_sign;
    logic [DATA_W-1:0]   ld_ext;

    // Decode the incoming request: alignment, byte enables, replicated store data
    always_comb begin
        req_off       = req_addr[OFF_W-1:0];
        req_aligned   = 1'b0;
        req_be        = '0;
        req_wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                req_aligned   = 1'b1;
                req_be        = BE_W'(1) << req_off;
                req_wdata_rep = {BE_W{req_wdata[7:0]}};
            end
            2'b01: begin
                req_aligned   = ~req_addr[0];
                req_be        = BE_W'(2'b11) << req_off;
                req_wdata_rep = {(DATA_W/16){req_wdata[15:0]}};
            end
            2'b10: begin
                req_aligned   = (req_addr[1:0] == 2'b00);
                req_be        = BE_W'(4'hF) << req_off;
                req_wdata_rep = {(DATA_W/32){req_wdata[31:0]}};
            end
            default: begin
                // dword only exists on a 64-bit bus
                req_aligned   = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
                req_be        = '1;
                req_wdata_rep = req_wdata;
            end
        endcase
        misaligned = (state_q == S_IDLE) && req_valid && !req_aligned;
        accept     = (state_q == S_IDLE) && req_valid && req_aligned && !flush;
    end

    // Right-justify the returned lane and zero/sign-extend according to size
    always_comb begin
        ld_shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   begin ld_mask = DATA_W'(8'hFF);         ld_sign = ld_shifted[7];  end
            2'b01:   begin ld_mask = DATA_W'(16'hFFFF);      ld_sign = ld_shifted[15]; end
            2'b10:   begin ld_mask = DATA_W'(32'hFFFF_FFFF); ld_sign = ld_shifted[31]; end
            default: begin ld_mask = '1;                     ld_sign = 1'b0;           end
        endcase
        ld_ext = (ld_shifted & ld_mask) | ({DATA_W{signed_q & ld_sign}} & ~ld_mask);
    end

    // Next-state and latched-request logic of the access FSM
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    off_d       = req_off;
                    mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_be_d    = req_be;
                    mem_wdata_d = req_wdata_rep;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    // A granted store is already posted; a granted load must have its data drained
                    if (flush) state_d = we_q ? S_IDLE : S_DRAIN;
                    else       state_d = we_q ? S_DONE : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // Data arriving together with the flush is simply dropped
                    state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    rsp_rdata_d = ld_ext;
                    state_d     = S_DONE;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Outputs: handshake and response decoded from the registered state
    always_comb begin
        stall     = accept || (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
        rsp_valid = (state_q == S_DONE);
        rsp_rdata = rsp_rdata_q;
        adel      = misaligned && !req_we;
        ades      = misaligned && req_we;
        badvaddr  = misaligned ? req_addr : '0;
        mem_req   = (state_q == S_REQ);
        mem_wr    = (state_q == S_REQ) && we_q;
        mem_be    = mem_be_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule
`default_nettype wire
